step_sequencer: RTL

Step sequencer that drives the `soundproc` voice, supplying its `tone_freq_bin` and `hold` inputs from a programmable pattern of note steps. The host programs the pattern through a simple write port. The block advances one step every `step_period` sample ticks and gates `hold` for a programmable fraction of each step. It guarantees a low gap on `hold` before every note, so `envelope_gen` sees a fresh rising edge and retriggers on each step.

---
 rtl/synth_pkg.sv | 17 +
 rtl/step_pattern_mem.sv | 40 ++++
 rtl/step_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
// Shared types and constants for the synth voice control blocks.
package synth_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE     = 2'd0,
        SEQ_GATE_ON  = 2'd1,
        SEQ_GATE_OFF = 2'd2
    } seq_state_e;

    localparam logic [1:0] GATE_QTR  = 2'd0;
    localparam logic [1:0] GATE_HALF = 2'd1;
    localparam logic [1:0] GATE_3QTR = 2'd2;
    localparam logic [1:0] GATE_FULL = 2'd3;

    localparam int unsigned MIN_STEP_PERIOD = 2;

endpackage

// File: rtl/step_pattern_mem.sv
// Register-file pattern store: async clear, one write port, one read port
// that forwards a same-cycle write to the address being read.
module step_pattern_mem #(
    parameter int  STEPS = 8,
    parameter int  WIDTH = 5,
    localparam int AW    = $clog2(STEPS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [STEPS];

    // Pattern storage; cleared to rests on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STEPS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read port with write-through bypass.
    always_comb begin
        rd_data = mem_q[rd_addr];
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_data = wr_data;
        end else begin
            rd_data = mem_q[rd_addr];
        end
    end

endmodule

// File: rtl/step_sequencer.sv
// Pattern step sequencer feeding tone code and hold gate to the soundproc voice.
// Each step opens the gate for a shift-derived fraction of the step period.
module step_sequencer
    import synth_pkg::*;
#(
    parameter int  STEPS      = 8,
    parameter int  FREQ_BITS  = 4,
    parameter int  TEMPO_BITS = 16,
    localparam int IDX_W      = $clog2(STEPS),
    localparam int ENT_W      = FREQ_BITS + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_tick,
    input  logic                  run,
    input  logic [TEMPO_BITS-1:0] step_period,
    input  logic [1:0]            gate_len,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_addr,
    input  logic [ENT_W-1:0]      wr_data,
    output logic [FREQ_BITS-1:0]  tone_freq_bin,
    output logic                  hold,
    output logic [IDX_W-1:0]      step_idx,
    output logic                  step_strobe
);

    seq_state_e            state_q, state_d;
    logic [TEMPO_BITS-1:0] cnt_q, cnt_d;
    logic [TEMPO_BITS-1:0] period_q, period_d;
    logic [1:0]            gate_q, gate_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [FREQ_BITS-1:0]  tone_q, tone_d;
    logic                  hold_q, hold_d;
    logic                  strobe_q, strobe_d;

    logic [IDX_W-1:0]      rd_addr_s;
    logic [ENT_W-1:0]      entry_s;
    logic [TEMPO_BITS-1:0] period_in_s;
    logic [TEMPO_BITS-1:0] on_raw_s;
    logic [TEMPO_BITS-1:0] on_len_s;
    logic                  period_end_s;
    logic                  gate_end_s;
    logic                  boundary_s;

    step_pattern_mem #(
        .STEPS (STEPS),
        .WIDTH (ENT_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr_s),
        .rd_data (entry_s)
    );

    // Entry read at the next boundary: step 0 on start, else the following step.
    always_comb begin
        rd_addr_s = '0;
        if (state_q == SEQ_IDLE) begin
            rd_addr_s = '0;
        end else begin
            rd_addr_s = idx_q + IDX_W'(1);
        end
    end

    // Clamp incoming period and derive gate length from the latched step values.
    always_comb begin
        period_in_s = step_period;
        if (step_period < TEMPO_BITS'(MIN_STEP_PERIOD)) begin
            period_in_s = TEMPO_BITS'(MIN_STEP_PERIOD);
        end else begin
            period_in_s = step_period;
        end

        case (gate_q)
            GATE_QTR:  on_raw_s = period_q >> 2'd2;
            GATE_HALF: on_raw_s = period_q >> 2'd1;
            GATE_3QTR: on_raw_s = (period_q >> 2'd1) + (period_q >> 2'd2);
            GATE_FULL: on_raw_s = period_q - TEMPO_BITS'(1);
            default:   on_raw_s = period_q - TEMPO_BITS'(1);
        endcase

        if (on_raw_s == '0) begin
            on_len_s = TEMPO_BITS'(1);
        end else begin
            on_len_s = on_raw_s;
        end
    end

    assign period_end_s = sample_tick && (cnt_q == (period_q - TEMPO_BITS'(1)));
    assign gate_end_s   = sample_tick && (cnt_q == (on_len_s - TEMPO_BITS'(1)));

    // Next-state: stop overrides everything, then boundary, then gate-off and counting.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        period_d   = period_q;
        gate_d     = gate_q;
        idx_d      = idx_q;
        tone_d     = tone_q;
        hold_d     = hold_q;
        strobe_d   = 1'b0;
        boundary_s = 1'b0;

        if (!run) begin
            state_d = SEQ_IDLE;
            hold_d  = 1'b0;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                SEQ_IDLE: begin
                    boundary_s = 1'b1;
                end
                SEQ_GATE_ON: begin
                    if (period_end_s) begin
                        boundary_s = 1'b1;
                    end else if (gate_end_s) begin
                        hold_d  = 1'b0;
                        state_d = SEQ_GATE_OFF;
                    end else begin
                        state_d = SEQ_GATE_ON;
                    end
                end
                SEQ_GATE_OFF: begin
                    if (period_end_s) begin
                        boundary_s = 1'b1;
                    end else begin
                        state_d = SEQ_GATE_OFF;
                    end
                end
                default: begin
                    state_d = SEQ_IDLE;
                    hold_d  = 1'b0;
                    idx_d   = '0;
                end
            endcase

            if (sample_tick && !boundary_s) begin
                cnt_d = cnt_q + TEMPO_BITS'(1);
            end else begin
                cnt_d = cnt_q;
            end

            // Boundary: latch tempo/gate, load the entry, restart the counter.
            if (boundary_s) begin
                cnt_d    = '0;
                strobe_d = 1'b1;
                period_d = period_in_s;
                gate_d   = gate_len;
                idx_d    = rd_addr_s;
                if (entry_s[FREQ_BITS]) begin
                    tone_d  = entry_s[FREQ_BITS-1:0];
                    hold_d  = 1'b1;
                    state_d = SEQ_GATE_ON;
                end else begin
                    hold_d  = 1'b0;
                    state_d = SEQ_GATE_OFF;
                end
            end else begin
                strobe_d = 1'b0;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= SEQ_IDLE;
            cnt_q    <= '0;
            period_q <= TEMPO_BITS'(MIN_STEP_PERIOD);
            gate_q   <= GATE_QTR;
            idx_q    <= '0;
            tone_q   <= '0;
            hold_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            gate_q   <= gate_d;
            idx_q    <= idx_d;
            tone_q   <= tone_d;
            hold_q   <= hold_d;
            strobe_q <= strobe_d;
        end
    end

    assign tone_freq_bin = tone_q;
    assign hold          = hold_q;
    assign step_idx      = idx_q;
    assign step_strobe   = strobe_q;

endmodule
